// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent TX and RX sharing one clock and reset.
// Define UART_FRAME_ERR_EN to add o_Rx_Frame_Err and drop bytes whose stop bit is 0.
module uart_txrx #(
   parameter int CLKS_PER_BIT = 86
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte
`ifdef UART_FRAME_ERR_EN
   ,
   output logic       o_Rx_Frame_Err
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_END = CW'(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP
   } state_e;

   state_e          tx_state_q;
   logic [CW-1:0]   tx_cnt_q;
   logic [2:0]      tx_idx_q;
   logic [7:0]      tx_byte_q;
   logic            tx_serial_q;
   logic            tx_active_q;
   logic            tx_done_q;

   state_e          rx_state_q;
   logic [CW-1:0]   rx_cnt_q;
   logic [2:0]      rx_idx_q;
   logic [7:0]      rx_shift_q;
   logic [7:0]      rx_byte_q;
   logic            rx_dv_q;
   logic [1:0]      rx_sync_q;
   logic            rx_line;

   assign rx_line = rx_sync_q[1];

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= '0;
         tx_byte_q   <= '0;
         tx_serial_q <= 1'b1;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         unique case (tx_state_q)
            S_IDLE: begin
               tx_serial_q <= 1'b1;
               tx_cnt_q    <= '0;
               tx_idx_q    <= '0;
               if (i_Tx_DV) begin
                  tx_byte_q   <= i_Tx_Byte;
                  tx_active_q <= 1'b1;
                  tx_state_q  <= S_START;
               end
            end
            S_START: begin
               tx_serial_q <= 1'b0;
               if (tx_cnt_q == BIT_END) begin
                  tx_cnt_q   <= '0;
                  tx_state_q <= S_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + ONE;
               end
            end
            S_DATA: begin
               tx_serial_q <= tx_byte_q[tx_idx_q];
               if (tx_cnt_q == BIT_END) begin
                  tx_cnt_q <= '0;
                  if (tx_idx_q == 3'd7) tx_state_q <= S_STOP;
                  else tx_idx_q <= tx_idx_q + 3'd1;
               end else begin
                  tx_cnt_q <= tx_cnt_q + ONE;
               end
            end
            // The line only follows the state one edge later, so the
            // stop state spans one extra edge to put Done at the bit end.
            S_STOP: begin
               tx_serial_q <= 1'b1;
               if (tx_cnt_q == STOP_END) begin
                  tx_cnt_q    <= '0;
                  tx_done_q   <= 1'b1;
                  tx_active_q <= 1'b0;
                  tx_state_q  <= S_CLEANUP;
               end else begin
                  tx_cnt_q <= tx_cnt_q + ONE;
               end
            end
            S_CLEANUP: tx_state_q <= S_IDLE;
            default:   tx_state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_sync_q  <= 2'b11;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_dv_q    <= 1'b0;
`ifdef UART_FRAME_ERR_EN
         o_Rx_Frame_Err <= 1'b0;
`endif
      end else begin
         rx_sync_q <= {rx_sync_q[0], i_Rx_Serial};
         rx_dv_q   <= 1'b0;
`ifdef UART_FRAME_ERR_EN
         o_Rx_Frame_Err <= 1'b0;
`endif
         unique case (rx_state_q)
            S_IDLE: begin
               rx_cnt_q <= '0;
               rx_idx_q <= '0;
               if (!rx_line) rx_state_q <= S_START;
            end
            S_START: begin
               if (rx_cnt_q == HALF) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= rx_line ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + ONE;
               end
            end
            S_DATA: begin
               if (rx_cnt_q == BIT_END) begin
                  rx_cnt_q <= '0;
                  rx_shift_q[rx_idx_q] <= rx_line;
                  if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
                  else rx_idx_q <= rx_idx_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + ONE;
               end
            end
            S_STOP: begin
               if (rx_cnt_q == BIT_END) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= S_CLEANUP;
`ifdef UART_FRAME_ERR_EN
                  if (rx_line) begin
                     rx_byte_q <= rx_shift_q;
                     rx_dv_q   <= 1'b1;
                  end else begin
                     o_Rx_Frame_Err <= 1'b1;
                  end
`else
                  rx_byte_q <= rx_shift_q;
                  rx_dv_q   <= 1'b1;
`endif
               end else begin
                  rx_cnt_q <= rx_cnt_q + ONE;
               end
            end
            S_CLEANUP: rx_state_q <= S_IDLE;
            default:   rx_state_q <= S_IDLE;
         endcase
      end
   end

   assign o_Tx_Active = tx_active_q;
   assign o_Tx_Serial = tx_serial_q;
   assign o_Tx_Done   = tx_done_q;
   assign o_Rx_DV     = rx_dv_q;
   assign o_Rx_Byte   = rx_byte_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: directed and random frames against a frame-level model.
// Works with or without UART_FRAME_ERR_EN.
module tb_uart_txrx;

   localparam int CPB = 86;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_Tx_DV = 1'b0;
   logic [7:0] i_Tx_Byte = 8'h00;
   logic       o_Tx_Active;
   logic       o_Tx_Serial;
   logic       o_Tx_Done;
   logic       i_Rx_Serial = 1'b1;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
`ifdef UART_FRAME_ERR_EN
   logic       o_Rx_Frame_Err;
`endif

   uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Tx_DV     (i_Tx_DV),
      .i_Tx_Byte   (i_Tx_Byte),
      .o_Tx_Active (o_Tx_Active),
      .o_Tx_Serial (o_Tx_Serial),
      .o_Tx_Done   (o_Tx_Done),
      .i_Rx_Serial (i_Rx_Serial),
      .o_Rx_DV     (o_Rx_DV),
`ifdef UART_FRAME_ERR_EN
      .o_Rx_Byte   (o_Rx_Byte),
      .o_Rx_Frame_Err (o_Rx_Frame_Err)
`else
      .o_Rx_Byte   (o_Rx_Byte)
`endif
   );

   always #50 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_Rx_DV) got_q.push_back(o_Rx_Byte);
         if (o_Tx_Done) done_cnt++;
`ifdef UART_FRAME_ERR_EN
         if (o_Rx_Frame_Err) err_cnt++;
`endif
      end
   end

   // Model: the line carries {stop=1, byte, start=0}, bit k for cycles
   // [k*CPB, (k+1)*CPB) after the fall; Done is seen FRAME cycles after it.
   task automatic tx_frame(input logic [7:0] b, input bit inject);
      logic       line [0:FRAME+1];
      logic [9:0] fr;
      int         d0;
      int         done_at;
      int         act_hi;
      fr = {1'b1, b, 1'b0};
      d0 = done_cnt;
      done_at = -1;
      act_hi = 0;
      i_Tx_DV = 1'b1;
      i_Tx_Byte = b;
      @(negedge clk);
      i_Tx_DV = 1'b0;
      i_Tx_Byte = 8'($urandom);
      chk("tx_pre_line", o_Tx_Serial, 1);
      chk("tx_pre_active", o_Tx_Active, 1);
      for (int t = 0; t <= FRAME + 1; t++) begin
         @(negedge clk);
         line[t] = o_Tx_Serial;
         if (o_Tx_Done && done_at < 0) done_at = t;
         if (t < FRAME && o_Tx_Active) act_hi++;
         if (t == FRAME) chk("tx_active_fall", o_Tx_Active, 0);
         if (inject && t == 400) begin
            i_Tx_DV = 1'b1;
            i_Tx_Byte = 8'h12;
         end else if (inject && t == 401) begin
            i_Tx_DV = 1'b0;
         end
      end
      for (int k = 0; k < 10; k++)
         chk($sformatf("tx_%02h_bit%0d", b, k),
             {line[k*CPB], line[k*CPB+CPB-1]}, {fr[k], fr[k]});
      chk("tx_done_time", done_at, FRAME);
      chk("tx_done_pulses", done_cnt - d0, 1);
      chk("tx_active_frame", act_hi, FRAME);
   endtask

   task automatic rx_send(input logic [7:0] b, input int start_len,
                          input int stop_len, input logic stop_val);
      i_Rx_Serial = 1'b0;
      repeat (start_len) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         i_Rx_Serial = b[i];
         repeat (CPB) @(negedge clk);
      end
      i_Rx_Serial = stop_val;
      repeat (stop_len) @(negedge clk);
      i_Rx_Serial = 1'b1;
   endtask

   task automatic rx_check(input string tag);
      int n;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #(400000 * 100);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rb;
      logic [7:0] tb_b;
      int         ext;
      int         d0;
      int         e0;
      repeat (3) @(negedge clk);
      chk("rst_tx_serial", o_Tx_Serial, 1);
      chk("rst_tx_active", o_Tx_Active, 0);
      chk("rst_tx_done", o_Tx_Done, 0);
      chk("rst_rx_dv", o_Rx_DV, 0);
      chk("rst_rx_byte", o_Rx_Byte, 0);
      rst_n = 1'b1;
      @(negedge clk);

      tx_frame(8'hAB, 1'b0);
      tx_frame(8'hAB, 1'b1);
      tx_frame(8'h00, 1'b0);

      i_Tx_DV = 1'b1;
      i_Tx_Byte = 8'hAB;
      @(negedge clk);
      i_Tx_DV = 1'b0;
      repeat (5 * CPB + 10) @(negedge clk);
      d0 = done_cnt;
      #10 rst_n = 1'b0;
      #1;
      chk("rst_mid_serial", o_Tx_Serial, 1);
      chk("rst_mid_active", o_Tx_Active, 0);
      chk("rst_mid_done", o_Tx_Done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      chk("rst_mid_no_done", done_cnt - d0, 0);
      chk("rst_mid_idle", o_Tx_Serial, 1);

      exp_q.push_back(8'h3B);
      rx_send(8'h3B, 96, CPB, 1'b1);
      repeat (100) @(negedge clk);
      rx_check("rx_3b");
      chk("rx_3b_hold", o_Rx_Byte, 8'h3B);

      i_Rx_Serial = 1'b0;
      repeat (20) @(negedge clk);
      i_Rx_Serial = 1'b1;
      repeat (300) @(negedge clk);
      rx_check("rx_glitch");
      exp_q.push_back(8'h55);
      rx_send(8'h55, CPB, CPB, 1'b1);
      repeat (100) @(negedge clk);
      rx_check("rx_55");

      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      rx_send(8'h00, CPB, CPB, 1'b1);
      rx_send(8'hFF, CPB, CPB, 1'b1);
      repeat (100) @(negedge clk);
      rx_check("rx_b2b");
      chk("rx_b2b_hold", o_Rx_Byte, 8'hFF);

      e0 = err_cnt;
      exp_q.push_back(8'hA5);
      rx_send(8'hA5, CPB, CPB, 1'b1);
`ifdef UART_FRAME_ERR_EN
      rx_send(8'hC3, CPB, 50, 1'b0);
      repeat (300) @(negedge clk);
      rx_check("rx_ferr");
      chk("rx_ferr_pulses", err_cnt - e0, 1);
      chk("rx_ferr_hold", o_Rx_Byte, 8'hA5);
`else
      exp_q.push_back(8'hC3);
      rx_send(8'hC3, CPB, 50, 1'b0);
      repeat (300) @(negedge clk);
      rx_check("rx_nostop");
      chk("rx_nostop_errs", err_cnt - e0, 0);
      chk("rx_nostop_hold", o_Rx_Byte, 8'hC3);
`endif

      for (int n = 0; n < 8; n++) begin
         rb = 8'($urandom);
         tb_b = 8'($urandom);
         ext = $urandom_range(0, CPB / 2 - 3);
         exp_q.push_back(rb);
         fork
            rx_send(rb, CPB + ext, CPB, 1'b1);
            tx_frame(tb_b, 1'b0);
         join
         repeat ($urandom_range(5, 30)) @(negedge clk);
         rx_check($sformatf("rx_rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
